// File: rtl/pe_pkg.sv
// Shared types and helpers for the vector MAC processing element.
package pe_pkg;

    // Default accumulator/result width used by the tile.
    localparam int PE_ACC_WIDTH = 32;

    // Result of a saturating clamp: flag plus clamped value.
    // The value is carried at 64 bits so one helper serves any ACC_WIDTH up to 63.
    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } clamp_t;

    // Exact width of a LANES-way sum of full-width DATA_WIDTH x DATA_WIDTH products.
    function automatic int sum_width(input int data_width, input int lanes);
        return 2 * data_width + $clog2(lanes);
    endfunction

    // Clamp a signed value into the acc_w-bit two's complement range.
    function automatic clamp_t sat_clamp(input logic signed [63:0] value, input int acc_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        clamp_t             r;
        hi    = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.sat = 1'b1;
        r.val = value;
        if (value > hi) begin
            r.val = hi;
        end else if (value < lo) begin
            r.val = lo;
        end else begin
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Combinational balanced binary adder tree over LANES signed operands.
// Each tree level widens by one bit, so the root is exact.
module pe_adder_tree #(
    parameter int IN_WIDTH = 16,
    parameter int LANES    = 4
) (
    input  logic        [LANES*IN_WIDTH-1:0]           in_flat,
    output logic signed [IN_WIDTH+$clog2(LANES)-1:0]   sum
);

    localparam int OW = IN_WIDTH + $clog2(LANES);

    // Heap-ordered nodes: root at 0, children of j at 2j+1 and 2j+2, leaves at LANES-1..
    logic signed [OW-1:0] node [2*LANES-1];

    // Load sign-extended leaves, then reduce pairwise from the bottom of the heap up.
    always_comb begin
        node = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            node[LANES-1+i] = OW'($signed(in_flat[i*IN_WIDTH +: IN_WIDTH]));
        end
        for (int j = LANES - 2; j >= 0; j--) begin
            node[j] = node[2*j+1] + node[2*j+2];
        end
        sum = node[0];
    end

endmodule

// File: rtl/mac_pe_vec.sv
// Vector multiply-accumulate PE: LANES products per beat, adder-tree reduction,
// saturating accumulation across beats, one result per in_last beat.
// Three stages (multiply, tree, accumulate); a stalled output freezes them all.
module mac_pe_vec
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]    in_w,
    input  logic [LANES*DATA_WIDTH-1:0]    in_x,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_WIDTH-1:0]    out_data,
    output logic                           out_sat
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = sum_width(DATA_WIDTH, LANES);

    // Full-precision signed lane product.
    function automatic logic signed [PW-1:0] mul_lane(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return PW'(a) * PW'(b);
    endfunction

    logic                       stall;
    logic [LANES*PW-1:0]        prod_c;
    logic [LANES*PW-1:0]        prod_p1;
    logic                       vld_p1;
    logic                       last_p1;
    logic signed [SW-1:0]       sum_c;
    logic signed [SW-1:0]       sum_p2;
    logic                       vld_p2;
    logic                       last_p2;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                       sat_sticky;
    logic signed [ACC_WIDTH:0]  t_c;
    clamp_t                     clamp_c;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic                       sat_nxt;

    // A held result that downstream refuses freezes the whole pipe.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Per-lane products of the incoming beat.
    always_comb begin
        prod_c = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_c[i*PW +: PW] = mul_lane(in_w[i*DATA_WIDTH +: DATA_WIDTH],
                                          in_x[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // ---- stage 1: multiply ----
    // Register products; operands are captured only on an actual transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            prod_p1 <= '0;
        end else if (!stall) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                last_p1 <= in_last;
                prod_p1 <= prod_c;
            end
        end
    end

    pe_adder_tree #(
        .IN_WIDTH (PW),
        .LANES    (LANES)
    ) u_tree (
        .in_flat (prod_p1),
        .sum     (sum_c)
    );

    // ---- stage 2: adder tree ----
    // Register the exact lane sum; invalid slots leave the data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            sum_p2  <= '0;
        end else if (!stall) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                last_p2 <= last_p1;
                sum_p2  <= sum_c;
            end
        end
    end

    // One guard bit above the accumulator makes the clamp decision exact.
    always_comb begin
        t_c     = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(sum_p2);
        clamp_c = sat_clamp(64'(t_c), ACC_WIDTH);
        acc_nxt = ACC_WIDTH'(clamp_c.val);
        sat_nxt = clamp_c.sat;
    end

    // ---- stage 3: accumulate / output ----
    // Accumulate non-final beats; a final beat publishes the result and clears state.
    // When not stalled any held result is being accepted, so out_valid simply
    // follows whether a new final beat retires (back-to-back without a bubble).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            sat_sticky <= 1'b0;
            out_data   <= '0;
            out_sat    <= 1'b0;
            out_valid  <= 1'b0;
        end else if (!stall) begin
            out_valid <= vld_p2 & last_p2;
            if (vld_p2) begin
                if (last_p2) begin
                    out_data   <= acc_nxt;
                    out_sat    <= sat_sticky | sat_nxt;
                    acc        <= '0;
                    sat_sticky <= 1'b0;
                end else begin
                    acc        <= acc_nxt;
                    sat_sticky <= sat_sticky | sat_nxt;
                end
            end
        end
    end

endmodule
